// File: rtl/floo_serial_link_vc_mux.sv
`default_nettype none
// ============================================================================
//  Module   : floo_serial_link_vc_mux
//  Purpose  : Credit-based round-robin multiplexer merging NumVc flit streams
//             onto a single serial-link data-link input. Each VC owns a credit
//             counter mirroring the free slots of the remote receiver buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module floo_serial_link_vc_mux #(
  parameter int unsigned NumVc      = 3,
  parameter int unsigned FlitWidth  = 64,
  parameter int unsigned NumCredits = 8,
  parameter int unsigned VcIdWidth  = (NumVc > 1) ? $clog2(NumVc) : 1,
  parameter int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumVc-1:0]              vc_enable_i,
  input  logic [NumVc*FlitWidth-1:0]    flit_i,
  input  logic [NumVc-1:0]              valid_i,
  output logic [NumVc-1:0]              ready_o,
  output logic [FlitWidth-1:0]          data_o,
  output logic [VcIdWidth-1:0]          vc_id_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  input  logic                          credit_valid_i,
  input  logic [VcIdWidth-1:0]          credit_vc_i,
  output logic [NumVc*CntWidth-1:0]     credits_o,
  output logic                          credit_err_o
);

  // Index space of a VcIdWidth-bit id; slots at or above NumVc are padding.
  localparam int unsigned VC_SLOTS   = 1 << VcIdWidth;
  localparam logic [CntWidth-1:0] CREDIT_MAX = CntWidth'(NumCredits);

  logic [CntWidth-1:0]    credit [NumVc];
  logic [VcIdWidth-1:0]   ptr;
  logic [NumVc-1:0]       eligible;
  logic [VC_SLOTS-1:0]    eligible_ext;
  logic [FlitWidth-1:0]   flit_arr [VC_SLOTS];
  logic [VcIdWidth-1:0]   grant;
  logic                   grant_found;
  logic [VcIdWidth:0]     cand;
  logic                   load;
  logic [NumVc-1:0]       overflow;
  logic                   vc_invalid;
  logic                   out_valid;
  logic [FlitWidth-1:0]   out_data;
  logic [VcIdWidth-1:0]   out_vc_id;
  logic                   credit_err;

  // Per-VC eligibility, flit unpacking, ready and credit bookkeeping.
  for (genvar v = 0; v < int'(VC_SLOTS); v++) begin : g_vc
    if (v < int'(NumVc)) begin : g_real
      logic dec;
      logic inc;

      assign eligible[v] = valid_i[v] & vc_enable_i[v] & (credit[v] != '0);
      assign flit_arr[v] = flit_i[v*FlitWidth +: FlitWidth];
      assign ready_o[v]  = load & (grant == VcIdWidth'(v));
      assign dec         = load & (grant == VcIdWidth'(v));
      assign inc         = credit_valid_i & (credit_vc_i == VcIdWidth'(v));
      // Returning a credit to an already-full counter is a protocol error.
      assign overflow[v] = inc & ~dec & (credit[v] == CREDIT_MAX);
      assign credits_o[v*CntWidth +: CntWidth] = credit[v];

      // Credit counter: +1 on return, -1 on grant, unchanged when both occur.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          credit[v] <= CREDIT_MAX;
        end else if (inc && !dec) begin
          if (credit[v] != CREDIT_MAX) begin
            credit[v] <= credit[v] + CntWidth'(1);
          end
        end else if (dec && !inc) begin
          credit[v] <= credit[v] - CntWidth'(1);
        end
      end
    end else begin : g_pad
      assign flit_arr[v] = '0;
    end
  end

  assign eligible_ext = VC_SLOTS'(eligible);
  assign vc_invalid   = credit_valid_i & (32'(credit_vc_i) >= NumVc);

  // Round-robin search starting at ptr; the first eligible VC wins.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int i = 0; i < int'(NumVc); i++) begin
      cand = {1'b0, ptr} + (VcIdWidth+1)'(i);
      if (cand >= (VcIdWidth+1)'(NumVc)) begin
        cand = cand - (VcIdWidth+1)'(NumVc);
      end
      if (!grant_found && eligible_ext[cand[VcIdWidth-1:0]]) begin
        grant_found = 1'b1;
        grant       = cand[VcIdWidth-1:0];
      end
    end
  end

  // The output register can take a new flit when empty or being drained.
  assign load = grant_found & (~out_valid | ready_i);

  // Round-robin pointer moves past the winner; a single VC needs no pointer.
  if (NumVc > 1) begin : g_ptr
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ptr <= '0;
      end else if (load) begin
        ptr <= (grant == VcIdWidth'(NumVc - 1)) ? '0 : grant + VcIdWidth'(1);
      end
    end
  end else begin : g_ptr_fixed
    assign ptr = '0;
  end

  // Output stage: hold while stalled, load on handshake, drop valid on drain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_vc_id <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= flit_arr[grant];
      out_vc_id <= grant;
    end else if (out_valid && ready_i) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky credit error flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_err <= 1'b0;
    end else if ((|overflow) || vc_invalid) begin
      credit_err <= 1'b1;
    end
  end

  assign valid_o      = out_valid;
  assign data_o       = out_data;
  assign vc_id_o      = out_vc_id;
  assign credit_err_o = credit_err;

endmodule
`default_nettype wire

// File: tb/tb_floo_serial_link_vc_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_floo_serial_link_vc_mux
//  Purpose  : Self-checking bench for floo_serial_link_vc_mux using a
//             transaction-level model of credits, round-robin and output reg.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_floo_serial_link_vc_mux;

  localparam int N  = 3;
  localparam int W  = 64;
  localparam int C  = 8;
  localparam int IW = 2;
  localparam int CW = 4;

  logic            clk_i;
  logic            rst_ni;
  logic [N-1:0]    vc_enable;
  logic [W-1:0]    fl [N];
  logic [N*W-1:0]  flit_i;
  logic [N-1:0]    valid_in;
  logic [N-1:0]    ready_o;
  logic [W-1:0]    data_o;
  logic [IW-1:0]   vc_id_o;
  logic            valid_o;
  logic            ready_in;
  logic            credit_valid;
  logic [IW-1:0]   credit_vc;
  logic [N*CW-1:0] credits_o;
  logic            credit_err_o;

  int checks   = 0;
  int failures = 0;

  // Model state
  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_vcid;
  int         m_ptr;
  int         m_cred [N];
  bit         m_err;

  assign flit_i = {fl[2], fl[1], fl[0]};

  floo_serial_link_vc_mux #(
    .NumVc(N), .FlitWidth(W), .NumCredits(C)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .vc_enable_i    (vc_enable),
    .flit_i         (flit_i),
    .valid_i        (valid_in),
    .ready_o        (ready_o),
    .data_o         (data_o),
    .vc_id_o        (vc_id_o),
    .valid_o        (valid_o),
    .ready_i        (ready_in),
    .credit_valid_i (credit_valid),
    .credit_vc_i    (credit_vc),
    .credits_o      (credits_o),
    .credit_err_o   (credit_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cred_of(input int v);
    return int'(credits_o[v*CW +: CW]);
  endfunction

  // Assert reset asynchronously, check reset state, resynchronise the model.
  task automatic do_reset();
    valid_in     = '0;
    credit_valid = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_valid_o", 64'(valid_o), 64'(0));
    chk("rst_data_o", data_o, 64'(0));
    chk("rst_vc_id_o", 64'(vc_id_o), 64'(0));
    chk("rst_credits", 64'(credits_o), 64'(12'h888));
    chk("rst_err", 64'(credit_err_o), 64'(0));
    chk("rst_ready_o", 64'(ready_o), 64'(0));
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    m_valid = 0; m_data = '0; m_vcid = 0; m_ptr = 0; m_err = 0;
    for (int v = 0; v < N; v++) m_cred[v] = C;
  endtask

  // One clock: check combinational ready, advance the model, check registers.
  task automatic cycle();
    int best;
    int mind;
    int d;
    bit load;
    bit inc;
    bit dec;
    logic [N-1:0] exp_rdy;
    @(negedge clk_i);
    best = -1;
    mind = N;
    for (int v = 0; v < N; v++) begin
      if (valid_in[v] && vc_enable[v] && m_cred[v] > 0) begin
        d = (v - m_ptr + N) % N;
        if (d < mind) begin
          mind = d;
          best = v;
        end
      end
    end
    load    = (best >= 0) && (!m_valid || ready_in);
    exp_rdy = load ? N'(1 << best) : '0;
    chk("ready_o", 64'(ready_o), 64'(exp_rdy));
    for (int v = 0; v < N; v++) begin
      dec = load && (best == v);
      inc = credit_valid && (int'(credit_vc) == v);
      if (inc && !dec) begin
        if (m_cred[v] == C) m_err = 1;
        else m_cred[v]++;
      end else if (dec && !inc) begin
        m_cred[v]--;
      end
    end
    if (credit_valid && int'(credit_vc) >= N) m_err = 1;
    if (load) begin
      m_valid = 1;
      m_data  = fl[best];
      m_vcid  = best;
      m_ptr   = (best + 1) % N;
    end else if (m_valid && ready_in) begin
      m_valid = 0;
    end
    @(posedge clk_i);
    #1;
    chk("valid_o", 64'(valid_o), 64'(m_valid));
    chk("data_o", data_o, m_data);
    chk("vc_id_o", 64'(vc_id_o), 64'(m_vcid));
    for (int v = 0; v < N; v++) chk("credits_o", 64'(cred_of(v)), 64'(m_cred[v]));
    chk("credit_err_o", 64'(credit_err_o), 64'(m_err));
  endtask

  initial begin
    bit seen1;
    rst_ni       = 1'b1;
    vc_enable    = '1;
    valid_in     = '0;
    ready_in     = 1'b1;
    credit_valid = 1'b0;
    credit_vc    = '0;
    for (int v = 0; v < N; v++) fl[v] = '0;
    do_reset();

    // VC0 exhausts its credits, then one returned credit releases flit 9.
    valid_in = 3'b001;
    for (int i = 0; i < 8; i++) begin
      fl[0] = 64'h100 + 64'(i);
      cycle();
    end
    chk("vc0_credits_empty", 64'(cred_of(0)), 64'(0));
    fl[0] = 64'h109;
    #2 chk("vc0_9th_blocked", 64'(ready_o), 64'(0));
    cycle();
    credit_valid = 1'b1;
    credit_vc    = 2'd0;
    #2 chk("vc0_credit_cycle_blocked", 64'(ready_o), 64'(0));
    cycle();
    credit_valid = 1'b0;
    #2 chk("vc0_released", 64'(ready_o), 64'(3'b001));
    cycle();
    chk("vc0_9th_data", data_o, 64'h109);

    // All VCs streaming with refill: strict 0,1,2 rotation with no bubbles.
    do_reset();
    valid_in = 3'b111;
    for (int k = 0; k < 9; k++) begin
      for (int v = 0; v < N; v++) fl[v] = {$urandom, $urandom};
      credit_valid = (k > 0);
      credit_vc    = IW'(m_vcid);
      cycle();
      chk("rr_vc_id", 64'(vc_id_o), 64'(k % 3));
      chk("rr_no_bubble", 64'(valid_o), 64'(1));
    end

    // Backpressure: 0xDEAD on VC1 held for five stalled cycles.
    credit_valid = 1'b0;
    valid_in     = 3'b010;
    fl[1]        = 64'hDEAD;
    cycle();
    ready_in = 1'b0;
    fl[1]    = 64'hBEEF;
    for (int k = 0; k < 5; k++) begin
      #2 chk("stall_ready", 64'(ready_o), 64'(0));
      cycle();
      chk("stall_data", data_o, 64'hDEAD);
      chk("stall_vc", 64'(vc_id_o), 64'(1));
      chk("stall_valid", 64'(valid_o), 64'(1));
      chk("stall_credit", 64'(cred_of(1)), 64'(7));
    end
    ready_in = 1'b1;
    valid_in = '0;
    cycle();

    // Credit corner cases on VC2.
    do_reset();
    valid_in = 3'b100;
    for (int k = 0; k < 5; k++) cycle();
    chk("vc2_at_3", 64'(cred_of(2)), 64'(3));
    credit_valid = 1'b1;
    credit_vc    = 2'd2;
    cycle();
    chk("vc2_same_cycle", 64'(cred_of(2)), 64'(3));
    valid_in = '0;
    for (int k = 0; k < 5; k++) cycle();
    chk("vc2_full_no_err", 64'(credit_err_o), 64'(0));
    cycle();
    chk("vc2_saturate", 64'(cred_of(2)), 64'(8));
    chk("vc2_overflow_err", 64'(credit_err_o), 64'(1));
    do_reset();
    credit_valid = 1'b1;
    credit_vc    = 2'd3;
    cycle();
    chk("bad_vc_err", 64'(credit_err_o), 64'(1));
    credit_valid = 1'b0;

    // VC1 masked: strict 0,2 alternation, then served soon after re-enable.
    do_reset();
    vc_enable = 3'b101;
    valid_in  = 3'b111;
    for (int k = 0; k < 8; k++) begin
      credit_valid = (k > 0);
      credit_vc    = IW'(m_vcid);
      cycle();
      chk("mask_vc_id", 64'(vc_id_o), 64'((k % 2) * 2));
    end
    vc_enable = 3'b111;
    seen1     = 0;
    for (int k = 0; k < 3; k++) begin
      credit_vc = IW'(m_vcid);
      cycle();
      if (vc_id_o == 2'd1) seen1 = 1;
    end
    chk("reenable_vc1_served", 64'(seen1), 64'(1));
    credit_valid = 1'b0;

    // Randomised traffic against the model, with a reset mid-run.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int v;
      valid_in  = N'($urandom);
      vc_enable = ($urandom % 8 == 0) ? N'($urandom) : 3'b111;
      ready_in  = ($urandom % 4) != 0;
      for (int j = 0; j < N; j++) fl[j] = {$urandom, $urandom};
      credit_valid = 1'b0;
      credit_vc    = IW'($urandom);
      if (i > 2800 && ($urandom % 8 == 0)) begin
        credit_valid = 1'b1;
      end else if ($urandom % 2 == 1) begin
        v = int'($urandom % N);
        credit_vc = IW'(v);
        credit_valid = (m_cred[v] < C);
      end
      if (i == 1500) begin
        do_reset();
      end else begin
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/floo_serial_link_vc_mux.md
Name: floo_serial_link_vc_mux

Overview:
Parametrised, credit-based virtual-channel multiplexer. Merges NumVc flit streams (e.g. narrow req, narrow rsp, wide) onto one serial-link data-link input. Round-robin arbitration with per-VC credit counters. It replaces the fixed narrow/wide three-channel split with an arbitrary VC count, VC masking and credit tracking.

Parameters:
NumVc, 3, number of virtual channels (≥1)
FlitWidth, 64, flit payload width in bits; narrower flits are zero-padded by the instantiator
NumCredits, 8, receiver buffer depth per VC; initial and maximum credit count (≥1)
VcIdWidth, max(1,$clog2(NumVc)), derived; do not override
CntWidth, $clog2(NumCredits+1), derived; do not override

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
vc_enable_i  in  NumVc  per-VC enable mask; a cleared bit removes that VC from arbitration
flit_i  in  NumVc*FlitWidth  per-VC flit payload
valid_i  in  NumVc  per-VC valid
ready_o  out  NumVc  per-VC ready
data_o  out  FlitWidth  muxed flit to link
vc_id_o  out  VcIdWidth  VC index of data_o
valid_o  out  1  link valid
ready_i  in  1  link ready
credit_valid_i  in  1  one credit returned by remote receiver
credit_vc_i  in  VcIdWidth  VC of returned credit
credits_o  out  NumVc*CntWidth  current credit count per VC
credit_err_o  out  1  sticky: credit overflow or invalid credit_vc_i

Behaviour:
- Reset values: valid_o=0, data_o=0, vc_id_o=0, every credit counter=NumCredits, RR pointer=0, credit_err_o=0, ready_o=0.
- Eligibility: eligible[v] = valid_i[v] & vc_enable_i[v] & (credit[v]!=0).
- Arbitration is round-robin. Search order is ptr, ptr+1, ... wrapping modulo NumVc. The first eligible VC gets the grant. The arbiter is combinational on the current-cycle inputs.
- Output stage is a single register. load = |eligible & (~valid_o | ready_i).
- ready_o[v] = grant[v] & load. At most one bit is set. ready_o does not depend on valid_i of other VCs beyond the arbitration result.
- On load:
  - data_o <= flit_i[grant] and vc_id_o <= grant; valid_o <= 1.
  - credit[grant] decrements by 1.
  - ptr <= (grant+1) mod NumVc.
- If valid_o & ready_i & ~load: valid_o <= 0. data_o and vc_id_o hold their values.
- If valid_o & ~ready_i: data_o, vc_id_o and valid_o are held stable. This is an AXI-style no-retraction rule.
- Latency: one cycle from the input handshake to valid_o. Back-to-back throughput is one flit per cycle while ready_i=1 and credits are available.
- Credit return: credit_valid_i increments credit[credit_vc_i] in the same edge.
  - If the same VC decrements in the same cycle, its count is unchanged.
  - Increment when the count is already NumCredits (and no same-cycle decrement): count saturates at NumCredits and credit_err_o is set.
  - credit_vc_i ≥ NumVc: ignored, and credit_err_o is set.
  - credit_err_o clears only on reset.
- Zero credits: the VC is not eligible and its ready_o=0. Other VCs proceed. A credit arriving in cycle t makes the VC eligible in cycle t+1.
- De-asserting vc_enable_i[v] with flit pending: that VC is never granted. A flit already in the output register is unaffected.
- No VC eligible: ptr is unchanged.
- credits_o is driven directly from the counter registers.
- NumVc=1: vc_id_o is tied to 0 and ptr is constant 0.
- Reset mid-transfer: the output flit is dropped and credits return to NumCredits. The remote side is reset by the same SoC reset.

Test Plan:
- Reset → valid_o=0, credit_err_o=0, every credits_o field=8.
- VC0 sends 8 flits with ready_i=1 and no credit return → 8 flits accepted, credits_o[0]=0. The 9th flit sees ready_o[0]=0. A single credit_valid_i(vc=0) lets the 9th flit go on the following cycle.
- All 3 VCs valid continuously, ready_i=1, credits refilled every cycle → vc_id_o sequence 0,1,2,0,1,2…; one flit per cycle, no bubbles.
- Output holds under backpressure: ready_i=0 for 5 cycles with flit 0xDEAD on VC1 → data_o=0xDEAD, vc_id_o=1, valid_o=1 held stable. No ready_o asserted and no credit decrement during the stall.
- Same-cycle credit return and grant on VC2 at credits=3 → credits_o[2] stays 3. An extra return at credits=8 → stays 8 and credit_err_o=1. credit_vc_i=3 → credit_err_o=1.
- vc_enable_i=3'b101 with all VCs valid → VC1 is never granted and the alternation is 0,2,0,2. Re-enabling VC1 → it is served within 3 grants.
